// File: rtl/genius_uc_pkg.sv
// Shared definitions for the Genius game control unit: state codes and LED mux selects.
package genius_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIO_RODADA = 4'h2,
    MOSTRA        = 4'h3,
    PROX_MOSTRA   = 4'h4,
    ZERA_JOGADA   = 4'h5,
    ESPERA        = 4'h6,
    REGISTRA      = 4'h7,
    COMPARA       = 4'h8,
    PROX_JOGADA   = 4'h9,
    PROX_RODADA   = 4'hA,
    GANHOU        = 4'hB,
    PERDEU        = 4'hC,
    TIMEOUT       = 4'hD
  } state_e;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_BOT = 2'b10;

endpackage

// File: rtl/genius_uc_if.sv
// Control/status bundle between the Genius control unit (slave side) and its datapath (master side).
interface genius_uc_if;
  logic       iniciar;
  logic       modo;
  logic       fimM;
  logic       endecoIgualLimite;
  logic       fimL;
  logic       jogada_feita;
  logic       botoesIgualMemoria;
  logic       timeout;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       zeraM;
  logic       contaM;
  logic       registraR;
  logic       contaT;
  logic       selecionaMemoria;
  logic [1:0] seletor;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       deu_timeout;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, modo, fimM, endecoIgualLimite, fimL, jogada_feita,
           botoesIgualMemoria, timeout,
    output zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, contaT,
           selecionaMemoria, seletor, pronto, ganhou, perdeu, deu_timeout, db_estado
  );

  modport master (
    output iniciar, modo, fimM, endecoIgualLimite, fimL, jogada_feita,
           botoesIgualMemoria, timeout,
    input  zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, contaT,
           selecionaMemoria, seletor, pronto, ganhou, perdeu, deu_timeout, db_estado
  );
endinterface

// File: rtl/genius_uc.sv
// Moore control unit for the Genius memory game.
// Optional macro GENIUS_TIMEOUT_EN enables the ESPERA timeout path (TIMEOUT state, contaT, deu_timeout).
module genius_uc
  import genius_pkg::*;
#(
  parameter bit ECHO_BUTTONS = 1'b1
) (
  input logic         clock,
  input logic         reset,
  genius_uc_if.slave  bus
);

  state_e state_q, state_d;
  logic   sel_mem_q;

`ifndef GENIUS_TIMEOUT_EN
  logic timeout_unused_s;
  assign timeout_unused_s = bus.timeout;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory select is captured once per game, while preparing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_mem_q <= 1'b0;
    end else if (state_q == PREPARA) begin
      sel_mem_q <= bus.modo;
    end else begin
      sel_mem_q <= sel_mem_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:       if (bus.iniciar) state_d = PREPARA; else state_d = INICIAL;
      PREPARA:       state_d = INICIO_RODADA;
      INICIO_RODADA: state_d = MOSTRA;
      MOSTRA: begin
        if (!bus.fimM)                 state_d = MOSTRA;
        else if (bus.endecoIgualLimite) state_d = ZERA_JOGADA;
        else                            state_d = PROX_MOSTRA;
      end
      PROX_MOSTRA:   state_d = MOSTRA;
      ZERA_JOGADA:   state_d = ESPERA;
      ESPERA: begin
        // A play arriving together with the timeout takes precedence
        if (bus.jogada_feita)    state_d = REGISTRA;
`ifdef GENIUS_TIMEOUT_EN
        else if (bus.timeout)    state_d = TIMEOUT;
`endif
        else                     state_d = ESPERA;
      end
      REGISTRA:      state_d = COMPARA;
      COMPARA: begin
        if (!bus.botoesIgualMemoria)     state_d = PERDEU;
        else if (!bus.endecoIgualLimite) state_d = PROX_JOGADA;
        else if (bus.fimL)               state_d = GANHOU;
        else                             state_d = PROX_RODADA;
      end
      PROX_JOGADA:   state_d = ESPERA;
      PROX_RODADA:   state_d = INICIO_RODADA;
      GANHOU, PERDEU, TIMEOUT: begin
        if (bus.iniciar) state_d = PREPARA;
        else             state_d = state_q;
      end
      default:       state_d = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.zeraE       = 1'b0;
    bus.contaE      = 1'b0;
    bus.zeraL       = 1'b0;
    bus.contaL      = 1'b0;
    bus.zeraR       = 1'b0;
    bus.zeraM       = 1'b0;
    bus.contaM      = 1'b0;
    bus.registraR   = 1'b0;
    bus.contaT      = 1'b0;
    bus.seletor     = SEL_OFF;
    bus.pronto      = 1'b0;
    bus.ganhou      = 1'b0;
    bus.perdeu      = 1'b0;
    bus.deu_timeout = 1'b0;
    case (state_q)
      PREPARA: begin
        bus.zeraE = 1'b1;
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
        bus.zeraM = 1'b1;
      end
      INICIO_RODADA: begin
        bus.zeraE = 1'b1;
        bus.zeraM = 1'b1;
      end
      MOSTRA: begin
        bus.seletor = SEL_MEM;
        bus.contaM  = 1'b1;
      end
      PROX_MOSTRA: begin
        bus.contaE = 1'b1;
        bus.zeraM  = 1'b1;
      end
      ZERA_JOGADA: begin
        bus.zeraE = 1'b1;
        bus.zeraR = 1'b1;
      end
      ESPERA: begin
`ifdef GENIUS_TIMEOUT_EN
        bus.contaT = 1'b1;
`endif
        bus.seletor = ECHO_BUTTONS ? SEL_BOT : SEL_OFF;
      end
      REGISTRA:    bus.registraR = 1'b1;
      PROX_JOGADA: bus.contaE    = 1'b1;
      PROX_RODADA: bus.contaL    = 1'b1;
      GANHOU: begin
        bus.ganhou = 1'b1;
        bus.pronto = 1'b1;
      end
      PERDEU: begin
        bus.perdeu = 1'b1;
        bus.pronto = 1'b1;
      end
      TIMEOUT: begin
`ifdef GENIUS_TIMEOUT_EN
        bus.deu_timeout = 1'b1;
`endif
        bus.pronto = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.selecionaMemoria = sel_mem_q;
  assign bus.db_estado        = state_q;

endmodule

// File: doc/genius_uc.md
Name: genius_uc

Overview:
- Control unit (Moore FSM) for the Genius memory game.
- Drives the datapath's counter, register and mux controls: clears, counts, registers, selects memory, selects LED source, enables the timeout counter.
- Consumes the datapath status flags and sequences each round: show sequence → collect plays → compare → next round / win / lose / timeout.
- Sits directly upstream of the datapath; the top level wires them 1:1.

Parameters:
- ECHO_BUTTONS, 1, when 1 drive seletor=2'b10 (LEDs mirror buttons) in ESPERA; when 0 drive 2'b00 there.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset); the polarity and synchronicity are fixed
- iniciar  input  1  level start request
- modo  input  1  memory select, sampled in PREPARA
- fimM, endecoIgualLimite, fimL, jogada_feita, botoesIgualMemoria, timeout  input  1 each  datapath status
- zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, contaT  output  1 each  datapath controls
- selecionaMemoria  output  1  registered copy of modo
- seletor  output  2  LED mux select: 00 = off, 01 = memory, 10 = buttons
- pronto, ganhou, perdeu, deu_timeout  output  1 each  end-of-game flags
- db_estado  output  4  current state code

Behaviour:
- State register: 4 bits, async reset to INICIAL.
- selecionaMemoria: a separate flop, async-cleared to 0, loaded from modo only in PREPARA.
- Outputs are Moore, decoded from state only; any control not listed for a state is 0.
- States and transitions:
  - INICIAL(0): no controls; iniciar → PREPARA.
  - PREPARA(1): zeraE, zeraL, zeraR, zeraM → INICIO_RODADA.
  - INICIO_RODADA(2): zeraE, zeraM → MOSTRA.
  - MOSTRA(3): seletor=01, contaM. On fimM: endecoIgualLimite → ZERA_JOGADA, else → PROX_MOSTRA.
  - PROX_MOSTRA(4): contaE, zeraM → MOSTRA.
  - ZERA_JOGADA(5): zeraE, zeraR → ESPERA.
  - ESPERA(6): contaT, seletor per ECHO_BUTTONS. Priority: jogada_feita → REGISTRA; else timeout → TIMEOUT.
  - REGISTRA(7): registraR → COMPARA.
  - COMPARA(8):
    - !botoesIgualMemoria → PERDEU
    - match and !endecoIgualLimite → PROX_JOGADA
    - match, at limit, fimL → GANHOU
    - match, at limit, !fimL → PROX_RODADA
  - PROX_JOGADA(9): contaE → ESPERA.
  - PROX_RODADA(A): contaL → INICIO_RODADA.
  - GANHOU(B): ganhou, pronto. PERDEU(C): perdeu, pronto. TIMEOUT(D): deu_timeout, pronto. From each: iniciar → PREPARA.
  - Codes E, F: unused; → INICIAL.
- contaT is high only in ESPERA. Leaving ESPERA therefore clears the datapath timeout counter.
- Play latency: jogada_feita seen in ESPERA → registraR 1 cycle later → compare result acted on 2 cycles later.
- Simultaneous events:
  - jogada_feita and timeout in the same cycle: the play wins.
  - iniciar held in a terminal state restarts exactly once per entry into PREPARA; holding iniciar does not skip PREPARA.
- Reset mid-game: immediate return to INICIAL, all outputs 0.

Optional Feature:
- Macro GENIUS_TIMEOUT_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - timeout input is ignored and contaT is tied to 0.
  - TIMEOUT state is unreachable; deu_timeout is constant 0.
  - ESPERA waits indefinitely for jogada_feita.

Decomposition:
- Package genius_pkg holds:
  - 4-bit state code constants INICIAL…TIMEOUT (values as above)
  - seletor codes SEL_OFF=00, SEL_MEM=01, SEL_BOT=10
- Single module; no sub-module is warranted.
- Next-state logic and output decode live in separate combinational blocks.

Test Plan:
- Reset low mid-MOSTRA → db_estado=0, all controls 0, selecionaMemoria=0 the same cycle.
- modo=1, pulse iniciar → states 0→1→2→3; selecionaMemoria=1; zeraL high one cycle in state 1.
- Round 1 (limit 0): fimM in MOSTRA with endecoIgualLimite=1 → 5→6; jogada_feita=1, botoesIgualMemoria=1, fimL=0 → 7→8→A (contaL pulse) →2.
- Round 2 with a wrong press: botoesIgualMemoria=0 in COMPARA → PERDEU (C); perdeu=1, pronto=1 held until iniciar.
- GENIUS_TIMEOUT_EN defined: hold in ESPERA, assert timeout → TIMEOUT (D), deu_timeout=1. Same cycle as jogada_feita → REGISTRA instead.
- Full game: every COMPARA matches, endecoIgualLimite=1, fimL=1 → GANHOU (B), ganhou=1. Then iniciar → PREPARA.
